tx_pause_sched: RTL and testbench

- Flow-control scheduler that drives the pause-frame request handshake (xreq/xon/xdone) of the transmit encapsulation block.
- Watches the receive FIFO fill level against XOFF/XON hysteresis thresholds and issues pause (XOFF) and resume (XON) requests.
- Re-sends XOFF before the advertised pause time expires.
- Sits between the RX buffer and tx_encap; configuration comes from MAC control registers.

---
 rtl/tx_pause_sched_if.sv | 25 ++
 rtl/tx_pause_sched.sv | 190 +++++++++++++++++++
 tb/tb_tx_pause_sched.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_pause_sched_if.sv
// rtl/tx_pause_sched_if.sv - pause-frame request handshake between tx_pause_sched and tx_encap
//
// Signals:
//   xreq  - pause-frame request (scheduler -> tx_encap)
//   xon   - 1 = XOFF frame with register pause value, 0 = zero-value XON frame
//   xdone - one-cycle pulse from tx_encap when the frame has been sent
// Modports: master = scheduler side, slave = tx_encap side.

interface tx_pause_sched_if;
    logic xreq;
    logic xon;
    logic xdone;

    modport master (
        output xreq,
        output xon,
        input  xdone
    );

    modport slave (
        input  xreq,
        input  xon,
        output xdone
    );
endinterface

// File: rtl/tx_pause_sched.sv
// rtl/tx_pause_sched.sv - RX-FIFO driven XOFF/XON pause-frame scheduler
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   pause_en          - enables automatic flow control
//   rxfifo_level      - current RX FIFO occupancy in words
//   xoff_thresh       - level at/above which XOFF is requested
//   xon_thresh        - level at/below which XON is requested
//   refresh_quanta    - quanta between XOFF refreshes, 0 = no refresh
//   clr_stat          - clears frame counters and req_timeout
//   encap             - xreq/xon/xdone handshake to tx_encap (master side)
//   paused            - link partner currently told to pause
//   cfg_err           - xon_thresh >= xoff_thresh (registered)
//   req_timeout       - sticky, xdone not received in time
//   xoff_cnt, xon_cnt - saturating counts of frames sent

module tx_pause_sched #(
    parameter int LVL_W         = 12,
    parameter int QUANTA_CYCLES = 8,
    parameter int XDONE_TO      = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pause_en,
    input  logic [LVL_W-1:0]    rxfifo_level,
    input  logic [LVL_W-1:0]    xoff_thresh,
    input  logic [LVL_W-1:0]    xon_thresh,
    input  logic [15:0]         refresh_quanta,
    input  logic                clr_stat,
    tx_pause_sched_if.master    encap,
    output logic                paused,
    output logic                cfg_err,
    output logic                req_timeout,
    output logic [15:0]         xoff_cnt,
    output logic [15:0]         xon_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_XOFF_REQ = 2'd1;
    localparam logic [1:0] S_PAUSED   = 2'd2;
    localparam logic [1:0] S_XON_REQ  = 2'd3;

    localparam int          PS_W      = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(QUANTA_CYCLES - 1);
    localparam logic [9:0]  WD_MAX    = 10'(XDONE_TO);

    logic [1:0]      state_q,     state_d;
    logic            xreq_q,      xreq_d;
    logic            xon_q,       xon_d;
    logic            paused_q,    paused_d;
    logic            timeout_q,   timeout_d;
    logic            cfg_err_q;
    logic [9:0]      wdog_q,      wdog_d;
    logic [15:0]     refresh_q,   refresh_d;
    logic [PS_W-1:0] presc_q,     presc_d;
    logic [15:0]     xoff_cnt_q,  xoff_cnt_d;
    logic [15:0]     xon_cnt_q,   xon_cnt_d;

    logic            wd_expired;
    logic            presc_tick;
    logic [15:0]     refresh_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign wd_expired = (wdog_q == WD_MAX);
    assign presc_tick = (presc_q == '0);
    // The refresh decision looks at the post-decrement count so the gap between
    // the end of one XOFF frame and the next request is exactly
    // refresh_quanta * QUANTA_CYCLES cycles.
    assign refresh_nxt = (presc_tick && refresh_q != 16'd0) ? refresh_q - 16'd1 : refresh_q;

    always_comb begin
        state_d    = state_q;
        xreq_d     = xreq_q;
        xon_d      = xon_q;
        paused_d   = paused_q;
        wdog_d     = wdog_q;
        refresh_d  = refresh_q;
        presc_d    = presc_q;
        // Clear first so a same-cycle increment lands on the cleared value.
        timeout_d  = timeout_q & ~clr_stat;
        xoff_cnt_d = clr_stat ? 16'd0 : xoff_cnt_q;
        xon_cnt_d  = clr_stat ? 16'd0 : xon_cnt_q;

        case (state_q)
            S_IDLE: begin
                xreq_d   = 1'b0;
                paused_d = 1'b0;
                if (pause_en && !cfg_err_q && rxfifo_level >= xoff_thresh) begin
                    state_d = S_XOFF_REQ;
                    xreq_d  = 1'b1;
                    xon_d   = 1'b1;
                    wdog_d  = 10'd0;
                end
            end
            S_XOFF_REQ: begin
                // A request in flight always completes; pause_en is only
                // re-examined once PAUSED is reached.
                if (encap.xdone) begin
                    state_d    = S_PAUSED;
                    xreq_d     = 1'b0;
                    paused_d   = 1'b1;
                    refresh_d  = refresh_quanta;
                    presc_d    = PS_RELOAD;
                    xoff_cnt_d = sat_inc(xoff_cnt_d);
                end else if (wd_expired) begin
                    state_d   = S_IDLE;
                    xreq_d    = 1'b0;
                    paused_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            S_PAUSED: begin
                presc_d   = presc_tick ? PS_RELOAD : presc_q - 1'b1;
                refresh_d = refresh_nxt;
                if (!pause_en || rxfifo_level <= xon_thresh) begin
                    state_d = S_XON_REQ;
                    xreq_d  = 1'b1;
                    xon_d   = 1'b0;
                    wdog_d  = 10'd0;
                end else if (refresh_quanta != 16'd0 && refresh_nxt == 16'd0 && !cfg_err_q) begin
                    state_d = S_XOFF_REQ;
                    xreq_d  = 1'b1;
                    xon_d   = 1'b1;
                    wdog_d  = 10'd0;
                end
            end
            S_XON_REQ: begin
                if (encap.xdone) begin
                    state_d   = S_IDLE;
                    xreq_d    = 1'b0;
                    paused_d  = 1'b0;
                    xon_cnt_d = sat_inc(xon_cnt_d);
                end else if (wd_expired) begin
                    state_d   = S_IDLE;
                    xreq_d    = 1'b0;
                    paused_d  = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                xreq_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // Threshold sanity is a free-running compare, independent of reset.
        cfg_err_q <= (xon_thresh >= xoff_thresh);
        if (rst) begin
            state_q    <= S_IDLE;
            xreq_q     <= 1'b0;
            xon_q      <= 1'b0;
            paused_q   <= 1'b0;
            timeout_q  <= 1'b0;
            wdog_q     <= 10'd0;
            refresh_q  <= 16'd0;
            presc_q    <= '0;
            xoff_cnt_q <= 16'd0;
            xon_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            xreq_q     <= xreq_d;
            xon_q      <= xon_d;
            paused_q   <= paused_d;
            timeout_q  <= timeout_d;
            wdog_q     <= wdog_d;
            refresh_q  <= refresh_d;
            presc_q    <= presc_d;
            xoff_cnt_q <= xoff_cnt_d;
            xon_cnt_q  <= xon_cnt_d;
        end
    end

    assign encap.xreq  = xreq_q;
    assign encap.xon   = xon_q;
    assign paused      = paused_q;
    assign cfg_err     = cfg_err_q;
    assign req_timeout = timeout_q;
    assign xoff_cnt    = xoff_cnt_q;
    assign xon_cnt     = xon_cnt_q;

endmodule

// File: tb/tb_tx_pause_sched.sv
// tb/tb_tx_pause_sched.sv - self-checking bench for tx_pause_sched

module tb_tx_pause_sched;

    localparam int LVL_W = 12;
    localparam int QC    = 8;
    localparam int XTO   = 1023;

    logic             clk = 1'b0;
    logic             rst;
    logic             pause_en;
    logic             clr_stat;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] xoff_th;
    logic [LVL_W-1:0] xon_th;
    logic [15:0]      rq;
    logic             paused;
    logic             cfg_err;
    logic             req_timeout;
    logic [15:0]      xoff_cnt;
    logic [15:0]      xon_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_xoff = 0;
    int exp_xon  = 0;

    tx_pause_sched_if pif ();

    tx_pause_sched #(
        .LVL_W         (LVL_W),
        .QUANTA_CYCLES (QC),
        .XDONE_TO      (XTO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pause_en       (pause_en),
        .rxfifo_level   (level),
        .xoff_thresh    (xoff_th),
        .xon_thresh     (xon_th),
        .refresh_quanta (rq),
        .clr_stat       (clr_stat),
        .encap          (pif),
        .paused         (paused),
        .cfg_err        (cfg_err),
        .req_timeout    (req_timeout),
        .xoff_cnt       (xoff_cnt),
        .xon_cnt        (xon_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_xdone();
        pif.xdone = 1'b1;
        tick();
        pif.xdone = 1'b0;
    endtask

    task automatic wait_xreq(input string tag);
        int n;
        n = 0;
        while (!pif.xreq && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, pif.xreq, 1);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_xoff_cnt"}, xoff_cnt, exp_xoff);
        check_eq({tag, "_xon_cnt"}, xon_cnt, exp_xon);
    endtask

    initial begin
        int n;
        rst = 1'b1; pause_en = 1'b0; clr_stat = 1'b0; pif.xdone = 1'b0;
        level = '0; xoff_th = 12'd100; xon_th = 12'd40; rq = 16'd0;
        repeat (3) tick();

        check_eq("rst_xreq", pif.xreq, 0);
        check_eq("rst_xon", pif.xon, 0);
        check_eq("rst_paused", paused, 0);
        check_eq("rst_timeout", req_timeout, 0);
        check_counts("rst");

        rst = 1'b0; pause_en = 1'b1;
        tick();
        check_eq("idle_low", pif.xreq, 0);

        // Basic XOFF then XON
        level = 12'd100; tick();
        check_eq("xoff_req", pif.xreq, 1);
        check_eq("xoff_req_xon", pif.xon, 1);
        pulse_xdone(); exp_xoff++;
        check_eq("xoff_done_xreq", pif.xreq, 0);
        check_eq("xoff_done_paused", paused, 1);
        check_counts("xoff_done");
        level = 12'd40; tick();
        check_eq("xon_req", pif.xreq, 1);
        check_eq("xon_req_xon", pif.xon, 0);
        pulse_xdone(); exp_xon++;
        check_eq("xon_done_xreq", pif.xreq, 0);
        check_eq("xon_done_paused", paused, 0);
        check_counts("xon_done");

        // Randomized thresholds, levels, refresh and xdone latency
        for (int it = 0; it < 20; it++) begin
            int xo, xn, lat, q, gap, hi, lo;
            xo = $urandom_range(50, 4000);
            xn = $urandom_range(0, xo - 1);
            q  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
            xoff_th = xo[LVL_W-1:0]; xon_th = xn[LVL_W-1:0]; rq = q[15:0];
            level = xn[LVL_W-1:0];
            tick(); tick();
            level = 12'(xo - 1); tick();
            check_eq("r_below_thresh", pif.xreq, 0);
            hi = $urandom_range(0, 1) ? xo : $urandom_range(xo, 4095);
            level = hi[LVL_W-1:0]; tick();
            check_eq("r_xoff_req", pif.xreq, 1);
            check_eq("r_xoff_xon", pif.xon, 1);
            lat = $urandom_range(0, 10);
            repeat (lat) tick();
            check_eq("r_xoff_hold", pif.xreq, 1);
            check_eq("r_xoff_hold_xon", pif.xon, 1);
            pulse_xdone(); exp_xoff++;
            check_eq("r_xoff_done", pif.xreq, 0);
            check_eq("r_paused", paused, 1);
            check_counts("r_xoff");
            if (q != 0) begin
                gap = 0;
                while (!pif.xreq && gap < 200) begin
                    tick();
                    gap++;
                end
                check_eq("r_refresh_gap", gap, q * QC);
                check_eq("r_refresh_xon", pif.xon, 1);
                pulse_xdone(); exp_xoff++;
                check_counts("r_refresh");
            end else begin
                n = 0;
                repeat ($urandom_range(0, 5)) begin
                    tick();
                    if (pif.xreq) n++;
                end
                check_eq("r_no_refresh", n, 0);
            end
            lo = $urandom_range(0, 1) ? xn : $urandom_range(0, xn);
            level = lo[LVL_W-1:0]; tick();
            check_eq("r_xon_req", pif.xreq, 1);
            check_eq("r_xon_xon", pif.xon, 0);
            check_eq("r_xon_paused", paused, 1);
            lat = $urandom_range(0, 10);
            repeat (lat) tick();
            check_eq("r_xon_hold_xon", pif.xon, 0);
            pulse_xdone(); exp_xon++;
            check_eq("r_xon_done", pif.xreq, 0);
            check_eq("r_xon_unpaused", paused, 0);
            check_counts("r_xon");
        end

        // Watchdog timeout: request is abandoned after XTO+1 cycles high
        xoff_th = 12'd100; xon_th = 12'd40; rq = 16'd0; level = '0;
        tick(); tick();
        level = 12'd150; tick();
        n = 0;
        while (pif.xreq && n < 1100) begin
            n++;
            tick();
        end
        pause_en = 1'b0;
        check_eq("timeout_len", n, XTO + 1);
        check_eq("timeout_flag", req_timeout, 1);
        check_eq("timeout_paused", paused, 0);
        tick();
        check_eq("timeout_idle", pif.xreq, 0);
        clr_stat = 1'b1; tick(); clr_stat = 1'b0;
        exp_xoff = 0; exp_xon = 0;
        check_eq("clr_timeout", req_timeout, 0);
        check_counts("clr");

        // clr_stat coincident with xdone: cleared then incremented
        pause_en = 1'b1; level = 12'd150; tick();
        check_eq("clr_xreq", pif.xreq, 1);
        pif.xdone = 1'b1; clr_stat = 1'b1; tick();
        pif.xdone = 1'b0; clr_stat = 1'b0;
        exp_xoff = 1;
        check_counts("clr_xdone");
        level = '0; tick();
        pulse_xdone(); exp_xon++;

        // xdone coincident with a level drop: PAUSED for one cycle, then XON
        level = 12'd150; tick();
        check_eq("coin_xreq", pif.xreq, 1);
        pif.xdone = 1'b1; level = 12'd20; tick(); pif.xdone = 1'b0; exp_xoff++;
        check_eq("coin_paused", paused, 1);
        check_eq("coin_gap", pif.xreq, 0);
        tick();
        check_eq("coin_xon_req", pif.xreq, 1);
        check_eq("coin_xon_val", pif.xon, 0);
        pulse_xdone(); exp_xon++;
        check_counts("coin");

        // pause_en dropped mid XOFF request: completes, then XON
        level = 12'd150; tick();
        pause_en = 1'b0; tick();
        check_eq("pe_xoff_held", pif.xreq, 1);
        pulse_xdone(); exp_xoff++;
        check_eq("pe_paused", paused, 1);
        tick();
        check_eq("pe_xon_req", pif.xreq, 1);
        check_eq("pe_xon_val", pif.xon, 0);
        pulse_xdone(); exp_xon++;
        check_eq("pe_unpaused", paused, 0);

        // xdone while idle is ignored
        level = '0; pause_en = 1'b1; tick();
        pulse_xdone();
        check_eq("idle_xdone_xreq", pif.xreq, 0);
        check_counts("idle_xdone");

        // cfg_err while PAUSED suppresses refresh but XON still works
        rq = 16'd1; level = 12'd200; tick();
        check_eq("cp_xreq", pif.xreq, 1);
        pulse_xdone(); exp_xoff++;
        xon_th = 12'd150;
        n = 0;
        repeat (40) begin
            tick();
            if (pif.xreq) n++;
        end
        check_eq("cp_cfg_err", cfg_err, 1);
        check_eq("cp_no_refresh", n, 0);
        level = 12'd100; tick();
        check_eq("cp_xon_req", pif.xreq, 1);
        check_eq("cp_xon_val", pif.xon, 0);
        pulse_xdone(); exp_xon++;
        check_counts("cp");

        // cfg_err from IDLE blocks XOFF entirely
        rq = 16'd0; xon_th = 12'd100; xoff_th = 12'd100; level = '0;
        tick(); tick();
        check_eq("cfg_err_set", cfg_err, 1);
        level = 12'd200;
        n = 0;
        repeat (30) begin
            tick();
            if (pif.xreq) n++;
        end
        check_eq("cfg_err_no_req", n, 0);
        xon_th = 12'd40; tick();
        check_eq("cfg_err_clr", cfg_err, 0);
        wait_xreq("cfg_ok_xreq");

        // Reset mid-request: xreq drops, counters clear, no XON owed
        rst = 1'b1; tick();
        exp_xoff = 0; exp_xon = 0;
        check_eq("rst_mid_xreq", pif.xreq, 0);
        check_eq("rst_mid_paused", paused, 0);
        check_counts("rst_mid");
        rst = 1'b0; level = '0;
        n = 0;
        repeat (10) begin
            tick();
            if (pif.xreq) n++;
        end
        check_eq("rst_no_xon", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
